// File: rtl/osd_hex_write_arbiter.sv
// osd_hex_write_arbiter: round-robin share of the OSD text_buffer write port.
// Each accepted request writes two uppercase ASCII hex chars at base, base+1.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   req_valid        per-requester pending flag, held until req_ready
//   req_value        8-bit value per requester, packed [8i+:8]
//   req_line         line index per requester, packed [LINE_W*i+:LINE_W]
//   req_col          column per requester, packed [COL_W*i+:COL_W]
//   req_ready        one-hot accept strobe (combinational)
//   vblank           accept gate, honoured only with OSD_ARB_VBLANK_GATE_EN
//   wr_en            text_buffer write strobe (registered)
//   wr_addr          text_buffer write address (registered, held when idle)
//   wr_data          ASCII char (registered, held when idle)
//   busy             high while in HI or LO
//   grant_id         requester currently being written
//
// Optional feature macro: OSD_ARB_VBLANK_GATE_EN
//   defined   -> new accepts (including LO->HI chaining) only while vblank=1
//   undefined -> vblank is ignored
module osd_hex_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 7,
  parameter int LINE_W = 3,
  parameter int COL_W  = 4,
  parameter int COLS   = 16,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [8*N_REQ-1:0]      req_value,
  input  logic [LINE_W*N_REQ-1:0] req_line,
  input  logic [COL_W*N_REQ-1:0]  req_col,
  output logic [N_REQ-1:0]        req_ready,
  input  logic                    vblank,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [7:0]              wr_data,
  output logic                    busy,
  output logic [ID_W-1:0]         grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [3:0]        lo_nib;
  logic [ADDR_W-1:0] base_q;

  logic              gate_open;
  logic              found;
  logic [ID_W-1:0]   winner;
  logic              accept;
  logic [7:0]        w_value;
  logic [LINE_W-1:0] w_line;
  logic [COL_W-1:0]  w_col;
  logic [ADDR_W-1:0] base_n;
  logic [ID_W-1:0]   ptr_n;

`ifdef OSD_ARB_VBLANK_GATE_EN
  assign gate_open = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign gate_open = 1'b1;
`endif

  function automatic logic [7:0] ascii(
    input logic [3:0] n
  );
    logic [7:0] r;
    unique case (1'b1)
      (n < 4'd10): r = 8'h30 + {4'h0, n};
      default:     r = 8'h37 + {4'h0, n};
    endcase
    return r;
  endfunction

  // First valid index at or above rr_ptr, wrapping.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ)
        idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // HI is the only state that cannot take a new request.
  assign accept = !reset && (state != HI) &&
                  gate_open && found;

  assign req_ready = accept ?
    (N_REQ'(1) << winner) : '0;

  assign w_value = req_value[8*winner +: 8];
  assign w_line  = req_line[LINE_W*winner +: LINE_W];
  assign w_col   = req_col[COL_W*winner +: COL_W];

  // Linear address, truncated; no clipping at line ends.
  assign base_n = ADDR_W'(32'(w_line) * 32'(COLS)
                          + 32'(w_col));

  assign ptr_n = (winner == ID_W'(N_REQ - 1)) ?
    '0 : winner + 1'b1;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lo_nib   <= '0;
      base_q   <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= '0;
    end else begin
      unique case (state)
        HI: begin
          state   <= LO;
          wr_en   <= 1'b1;
          wr_addr <= base_q + 1'b1;
          wr_data <= ascii(lo_nib);
        end
        default: begin
          if (accept) begin
            state    <= HI;
            rr_ptr   <= ptr_n;
            lo_nib   <= w_value[3:0];
            base_q   <= base_n;
            grant_id <= winner;
            wr_en    <= 1'b1;
            wr_addr  <= base_n;
            wr_data  <= ascii(w_value[7:4]);
          end else begin
            state <= IDLE;
            wr_en <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_osd_hex_write_arbiter.sv
// tb_osd_hex_write_arbiter: directed bench with a queue-based write model.
// Expected writes are derived from the request stream, not from FSM states.
module tb_osd_hex_write_arbiter;

  localparam int N   = 4;
  localparam int AW  = 7;
  localparam int LW  = 3;
  localparam int CW  = 4;
  localparam int CLS = 16;
  localparam int IW  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0]  req_value;
  logic [LW*N-1:0] req_line;
  logic [CW*N-1:0] req_col;
  logic [N-1:0]  req_ready;
  logic          vblank;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;
  logic [IW-1:0] grant_id;

  osd_hex_write_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .LINE_W(LW),
    .COL_W(CW), .COLS(CLS)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_value(req_value),
    .req_line(req_line), .req_col(req_col),
    .req_ready(req_ready), .vblank(vblank),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int id;
  } wr_t;

  wr_t    q[$];
  wr_t    wlog[$];
  wr_t    last;
  int     ptr;
  logic [N-1:0] hold;
  string  hexs = "0123456789ABCDEF";

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm,
                     input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic set_req(input int i, input int v,
                         input int ln, input int cl);
    req_value[8*i +: 8]   = 8'(v);
    req_line[LW*i +: LW]  = LW'(ln);
    req_col[CW*i +: CW]   = CW'(cl);
    req_valid[i]          = 1'b1;
  endtask

  function automatic bit gate_ok();
`ifdef OSD_ARB_VBLANK_GATE_EN
    return vblank == 1'b1;
`else
    return 1'b1;
`endif
  endfunction

  task automatic step(input int n);
    for (int c = 0; c < n; c++) begin
      logic [N-1:0] er;
      int  win;
      wr_t cur;
      wr_t e;
      @(negedge clk);
      er  = '0;
      win = -1;
      if (!reset && q.size() < 2 && gate_ok()) begin
        for (int k = 0; k < N; k++) begin
          int ix;
          ix = (ptr + k) % N;
          if (win < 0 && req_valid[ix])
            win = ix;
        end
        if (win >= 0)
          er[win] = 1'b1;
      end
      cur = (q.size() != 0) ? q[0] : last;
      chk("req_ready", int'(req_ready), int'(er));
      chk("wr_en", int'(wr_en), int'(q.size() != 0));
      chk("busy", int'(busy), int'(q.size() != 0));
      chk("wr_addr", int'(wr_addr), cur.addr);
      chk("wr_data", int'(wr_data), cur.data);
      chk("grant_id", int'(grant_id), cur.id);
      if (wr_en) begin
        e.addr = int'(wr_addr);
        e.data = int'(wr_data);
        e.id   = int'(grant_id);
        wlog.push_back(e);
      end
      if (reset) begin
        q.delete();
        ptr  = 0;
        last = '{0, 0, 0};
      end else begin
        if (q.size() != 0)
          last = q.pop_front();
        if (win >= 0) begin
          int v, b;
          v = int'(req_value[8*win +: 8]);
          b = (int'(req_line[LW*win +: LW]) * CLS
               + int'(req_col[CW*win +: CW])) % 128;
          e.id   = win;
          e.addr = b;
          e.data = int'(hexs[v / 16]);
          q.push_back(e);
          e.addr = (b + 1) % 128;
          e.data = int'(hexs[v % 16]);
          q.push_back(e);
          ptr = (win + 1) % N;
        end
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~(er & ~hold);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    wlog.delete();
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_value = '0;
    req_line  = '0;
    req_col   = '0;
    vblank    = 1'b1;
    hold      = '0;
    last      = '{0, 0, 0};
    ptr       = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    step(2);
    reset = 1'b0;
    step(2);

    // 1: single request, mid-screen
    wlog.delete();
    set_req(0, 8'h3C, 1, 8);
    step(4);
    chk("t1_n", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t1_a0", wlog[0].addr, 24);
      chk("t1_d0", wlog[0].data, 8'h33);
      chk("t1_a1", wlog[1].addr, 25);
      chk("t1_d1", wlog[1].data, 8'h43);
    end

    // 2: two simultaneous requests, back-to-back stream
    do_reset();
    set_req(0, 8'h12, 0, 0);
    set_req(1, 8'hEF, 2, 4);
    step(6);
    chk("t2_n", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("t2_a0", wlog[0].addr, 0);
      chk("t2_d0", wlog[0].data, 8'h31);
      chk("t2_a1", wlog[1].addr, 1);
      chk("t2_d1", wlog[1].data, 8'h32);
      chk("t2_a2", wlog[2].addr, 36);
      chk("t2_d2", wlog[2].data, 8'h45);
      chk("t2_a3", wlog[3].addr, 37);
      chk("t2_d3", wlog[3].data, 8'h46);
    end

    // 3: two held requesters alternate
    do_reset();
    hold = 4'b0011;
    set_req(0, 8'h01, 0, 0);
    set_req(1, 8'h02, 1, 0);
    step(7);
    req_valid = '0;
    hold      = '0;
    step(4);
    chk("t3_n", wlog.size(), 8);
    if (wlog.size() == 8)
      for (int i = 0; i < 8; i++)
        chk("t3_gid", wlog[i].id, (i / 2) % 2);

    // 4: last cell, lo char wraps to address 0
    wlog.delete();
    set_req(3, 8'hA5, 7, 15);
    step(4);
    chk("t4_n", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t4_a0", wlog[0].addr, 127);
      chk("t4_d0", wlog[0].data, 8'h41);
      chk("t4_a1", wlog[1].addr, 0);
      chk("t4_d1", wlog[1].data, 8'h35);
    end

    // 5: reset during the HI cycle
    wlog.delete();
    set_req(2, 8'h5A, 0, 2);
    step(1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t5_wr_en", int'(wr_en), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_gid", int'(grant_id), 0);
    step(3);
    chk("t5_n", wlog.size(), 1);
    if (wlog.size() == 1)
      chk("t5_d0", wlog[0].data, 8'h35);

    // 6: request while vblank low, then vblank rises
    wlog.delete();
    vblank = 1'b0;
    set_req(2, 8'h7E, 3, 0);
    step(3);
    vblank = 1'b1;
    step(4);
    chk("t6_n", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t6_a0", wlog[0].addr, 48);
      chk("t6_d0", wlog[0].data, 8'h37);
      chk("t6_a1", wlog[1].addr, 49);
      chk("t6_d1", wlog[1].data, 8'h45);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
